// File: rtl/qam_pkg.sv
// qam_pkg: constants and helpers shared by the 16QAM modulator shaper and demod_lpf
//   N      : index of the last filter tap (taps b[0..N])
//   ACC_W  : accumulator width of the MAC
//   SHIFT  : output scaling shift applied to the accumulator
//   B      : symmetric 9-tap low-pass coefficients
//   gray() : Gray-coded 2-bit field to signed amplitude
package qam_pkg;
    localparam int N     = 8;
    localparam int ACC_W = 16;
    localparam int SHIFT = 7;
    localparam logic signed [7:0] B [0:N] = '{
        8'sd16, 8'sd46, 8'sd74, 8'sd95, 8'sd102, 8'sd95, 8'sd74, 8'sd46, 8'sd16
    };

    function automatic logic signed [7:0] gray(input logic [1:0] f);
        return f == 2'b00 ? -8'sd96 :
               f == 2'b01 ? -8'sd32 :
               f == 2'b11 ?  8'sd32 : 8'sd96;
    endfunction
endpackage

// File: rtl/mod_shaper_if.sv
// mod_shaper_if: symbol handshake and shaped sample bus of the 16QAM shaper
//   sym/sym_valid/sym_ready : symbol transfer (sym[3:2] = I field, sym[1:0] = Q field)
//   out_i/out_q             : signed shaped samples, one pair per clock
//   sym_strobe/underrun     : one-cycle slot status pulses
interface mod_shaper_if;
    logic [3:0] sym;
    logic       sym_valid;
    logic       sym_ready;
    logic [7:0] out_i;
    logic [7:0] out_q;
    logic       sym_strobe;
    logic       underrun;

    modport master (output sym, sym_valid, input sym_ready, out_i, out_q, sym_strobe, underrun);
    modport slave  (input sym, sym_valid, output sym_ready, out_i, out_q, sym_strobe, underrun);
endinterface

// File: rtl/mod_fir.sv
// mod_fir: one rail of the pulse shaper -- delay line, 9-tap MAC, floor shift and saturation
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : zero-stuffed signed impulse entering d[0]
//   dout       : registered signed shaped sample
module mod_fir
    import qam_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [7:0] din,
    output logic signed [7:0] dout
);
    logic signed [7:0]       d [0:N];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sh;
    logic signed [7:0]       sat;

    // The output register sees the delay line as it was before the edge,
    // so a sample loaded into d[0] at edge t shows b[0] at edge t+1.
    always_comb begin
        acc = '0;
        for (int k = 0; k <= N; k++)
            acc = acc + ACC_W'(d[k]) * ACC_W'(B[k]);
    end

    assign sh  = acc >>> SHIFT;
    assign sat = sh > 127 ? 8'h7f : sh < -128 ? 8'h80 : sh[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= N; k++)
                d[k] <= '0;
            dout <= '0;
        end else begin
            d[0] <= din;
            for (int k = 1; k <= N; k++)
                d[k] <= d[k-1];
            dout <= sat;
        end
    end
endmodule

// File: rtl/mod_shaper.sv
// mod_shaper: 16QAM transmit pulse shaper -- Gray map, OSR zero-stuffing, shared 9-tap FIR per rail
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mod_shaper_if (symbol handshake in, shaped I/Q and status out)
//   OSR        : samples per symbol, power of two in 2..16
module mod_shaper
    import qam_pkg::*;
#(
    parameter int OSR = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mod_shaper_if.slave  bus
);
    localparam int PW = $clog2(OSR);

    logic [PW-1:0]     phase;
    logic              hold_v;
    logic [3:0]        hold;
    logic              slot;
    logic              take;
    logic signed [7:0] din_i;
    logic signed [7:0] din_q;
    logic signed [7:0] y_i;
    logic signed [7:0] y_q;
    logic              strobe;
    logic              under;

    assign slot = phase == '0;
    assign take = bus.sym_valid & ~hold_v;

    // Only a phase-0 edge with a held symbol injects an impulse; every other
    // edge stuffs a zero.
    assign din_i = slot & hold_v ? gray(hold[3:2]) : '0;
    assign din_q = slot & hold_v ? gray(hold[1:0]) : '0;

    // phase wraps naturally because OSR is a power of two.  A symbol offered
    // on a phase-0 edge with the register empty is loaded but not consumed
    // until the next slot, so that slot still reports an underrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= '0;
            hold_v <= 1'b0;
            hold   <= '0;
            strobe <= 1'b0;
            under  <= 1'b0;
        end else begin
            phase  <= phase + 1'b1;
            hold_v <= take | (hold_v & ~slot);
            hold   <= take ? bus.sym : hold;
            strobe <= slot & hold_v;
            under  <= slot & ~hold_v;
        end
    end

    mod_fir u_fir_i (.clk(clk), .rst_n(rst_n), .din(din_i), .dout(y_i));
    mod_fir u_fir_q (.clk(clk), .rst_n(rst_n), .din(din_q), .dout(y_q));

    assign bus.sym_ready  = ~hold_v;
    assign bus.out_i      = y_i;
    assign bus.out_q      = y_q;
    assign bus.sym_strobe = strobe;
    assign bus.underrun   = under;
endmodule
